// File: rtl/sat_up_pkg.sv
//------------------------------------------------------------------------------
// Module : sat_up_pkg
// Brief  : Shared FSM state type, tail length, RSC generators and block limits
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sat_up_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL1 = 2'd2,
        ST_TAIL2 = 2'd3
    } state_t;

    localparam int         TAIL_LEN  = 3;
    // Octal 13 feedback / 15 parity; bit 3 is the input tap, [2:0] map onto {s0,s1,s2}
    localparam logic [3:0] G0        = 4'b1011;
    localparam logic [3:0] G1        = 4'b1101;
    localparam int         K_MIN_DEF = 40;
    localparam int         K_MAX_DEF = 6144;
    localparam int         CNT_W_DEF = 16;

endpackage

`default_nettype wire

// File: rtl/sat_up_rsc_enc.sv
//------------------------------------------------------------------------------
// Module : sat_up_rsc_enc
// Brief  : 8-state recursive systematic convolutional encoder with trellis tail
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_up_rsc_enc
    import sat_up_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic       term,
    input  logic       u,
    output logic       x,
    output logic       z,
    output logic [2:0] state
);

    logic [2:0] r_state;
    logic       w_fb;
    logic       w_u;
    logic       w_a;

    // During termination the input cancels the feedback so the register drains to zero
    always_comb begin
        w_fb = ^(G0[2:0] & r_state);
        w_u  = term ? w_fb : u;
        w_a  = w_u ^ w_fb;
    end

    assign x     = w_u;
    assign z     = w_a ^ (^(G1[2:0] & r_state));
    assign state = r_state;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= 3'b000;
        end else if (clr) begin
            r_state <= 3'b000;
        end else if (en) begin
            r_state <= {w_a, r_state[2:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/sat_up_turbo_enc.sv
//------------------------------------------------------------------------------
// Module : sat_up_turbo_enc
// Brief  : PCCC turbo encoder: two RSC encoders plus per-encoder trellis tail
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_up_turbo_enc
    import sat_up_pkg::*;
#(
    parameter int K_MIN = K_MIN_DEF,
    parameter int K_MAX = K_MAX_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] blk_len,
    input  logic             in_valid,
    input  logic             in_sys,
    input  logic             in_itl,
    output logic             out_valid,
    output logic             out_sys,
    output logic             out_p1,
    output logic             out_p2,
    output logic             out_tail,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_k_min     = CNT_W'(K_MIN);
    localparam logic [CNT_W-1:0] c_k_max     = CNT_W'(K_MAX);
    localparam logic [1:0]       c_tail_last = 2'(TAIL_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_tcnt;
    logic             r_sop_pend;

    logic             w_accept;
    logic             w_consume;
    logic             w_err_evt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_x1, w_z1, w_x2, w_z2;
    logic [2:0]       w_st1, w_st2;

    assign w_accept  = start && (r_state == ST_IDLE) && (blk_len >= c_k_min) && (blk_len <= c_k_max);
    assign w_consume = (r_state == ST_DATA) && in_valid;
    assign w_err_evt = (start && !w_accept) || (in_valid && (r_state != ST_DATA));
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    sat_up_rsc_enc u_rsc1 (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (w_accept),
        .en    (w_consume || (r_state == ST_TAIL1)),
        .term  (r_state == ST_TAIL1),
        .u     (in_sys),
        .x     (w_x1),
        .z     (w_z1),
        .state (w_st1)
    );

    sat_up_rsc_enc u_rsc2 (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (w_accept),
        .en    (w_consume || (r_state == ST_TAIL2)),
        .term  (r_state == ST_TAIL2),
        .u     (in_itl),
        .x     (w_x2),
        .z     (w_z2),
        .state (w_st2)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_cnt      <= '0;
            r_tcnt     <= 2'd0;
            r_sop_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_sys    <= 1'b0;
            out_p1     <= 1'b0;
            out_p2     <= 1'b0;
            out_tail   <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sys   <= 1'b0;
            out_p1    <= 1'b0;
            out_p2    <= 1'b0;
            out_tail  <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            // A fresh start clears the sticky flag, but a fault in the same cycle still sets it
            err       <= (w_accept ? 1'b0 : err) | w_err_evt;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_k        <= blk_len;
                        r_cnt      <= '0;
                        r_sop_pend <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (in_valid) begin
                        out_valid  <= 1'b1;
                        out_sys    <= in_sys;
                        out_p1     <= w_z1;
                        out_p2     <= w_z2;
                        out_sop    <= r_sop_pend;
                        r_sop_pend <= 1'b0;
                        r_cnt      <= w_cnt_nxt;
                        if (w_cnt_nxt == r_k) begin
                            r_tcnt  <= 2'd0;
                            r_state <= ST_TAIL1;
                        end
                    end
                end
                ST_TAIL1: begin
                    out_valid <= 1'b1;
                    out_tail  <= 1'b1;
                    out_sys   <= w_x1;
                    out_p1    <= w_z1;
                    r_tcnt    <= r_tcnt + 2'd1;
                    if (r_tcnt == c_tail_last) begin
                        r_tcnt  <= 2'd0;
                        r_state <= ST_TAIL2;
                    end
                end
                ST_TAIL2: begin
                    out_valid <= 1'b1;
                    out_tail  <= 1'b1;
                    out_sys   <= w_x2;
                    out_p1    <= w_z2;
                    r_tcnt    <= r_tcnt + 2'd1;
                    if (r_tcnt == c_tail_last) begin
                        r_tcnt  <= 2'd0;
                        out_eop <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    a_rsc1_terminated: assert property (@(posedge clk) disable iff (!n_rst)
        (r_state == ST_TAIL1 && r_tcnt == c_tail_last) |=> (w_st1 == 3'b000));

    a_both_terminated: assert property (@(posedge clk) disable iff (!n_rst)
        (r_state == ST_TAIL2 && r_tcnt == c_tail_last) |=> (w_st1 == 3'b000 && w_st2 == 3'b000));

endmodule

`default_nettype wire

// File: tb/tb_sat_up_turbo_enc.sv
//------------------------------------------------------------------------------
// Module : tb_sat_up_turbo_enc
// Brief  : Scoreboard bench for sat_up_turbo_enc with an independent RSC model
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sat_up_turbo_enc;

    localparam int CNT_W = 16;

    logic             clk      = 1'b0;
    logic             n_rst    = 1'b0;
    logic             start    = 1'b0;
    logic [CNT_W-1:0] blk_len  = '0;
    logic             in_valid = 1'b0;
    logic             in_sys   = 1'b0;
    logic             in_itl   = 1'b0;
    logic             out_valid, out_sys, out_p1, out_p2, out_tail, out_sop, out_eop, busy, err;

    sat_up_turbo_enc #(.K_MIN(40), .K_MAX(6144), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .blk_len   (blk_len),
        .in_valid  (in_valid),
        .in_sys    (in_sys),
        .in_itl    (in_itl),
        .out_valid (out_valid),
        .out_sys   (out_sys),
        .out_p1    (out_p1),
        .out_p2    (out_p2),
        .out_tail  (out_tail),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_miss = 0;
    int         n_out = 0;
    logic [5:0] sb[$];
    logic       cap_p1[$];
    logic       cap_p2[$];
    logic [3:1] m1, m2;
    logic       sop_exp;
    logic [5:0] mon_got, mon_exp;

    // Delay-line model: d[1] newest. Returns {x, z, next d[3:1]}
    function automatic logic [4:0] rsc_ref(input logic [3:1] d, input logic u, input logic term);
        logic uu, fb, par;
        uu  = term ? (d[2] ^ d[3]) : u;
        fb  = uu ^ d[2] ^ d[3];
        par = fb ^ d[1] ^ d[3];
        return {uu, par, d[2], d[1], fb};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    // Monitor: every presented triplet {sys,p1,p2,tail,sop,eop} is popped against the scoreboard
    always @(negedge clk) begin
        if (n_rst && out_valid) begin
            mon_got = {out_sys, out_p1, out_p2, out_tail, out_sop, out_eop};
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected triplet %0d: got %b want none", n_out, mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_miss++;
                    $display("FAIL triplet %0d: got %b want %b", n_out, mon_got, mon_exp);
                end
            end
            if (!out_tail) begin
                cap_p1.push_back(out_p1);
                cap_p2.push_back(out_p2);
            end
            n_out++;
        end
    end

    task automatic start_block(input int k);
        start   = 1'b1;
        blk_len = CNT_W'(k);
        @(negedge clk);
        start   = 1'b0;
        m1      = '0;
        m2      = '0;
        sop_exp = 1'b1;
        n_out   = 0;
        cap_p1.delete();
        cap_p2.delete();
    endtask

    task automatic feed(input logic s, input logic t);
        logic [4:0] r1, r2;
        r1 = rsc_ref(m1, s, 1'b0);
        r2 = rsc_ref(m2, t, 1'b0);
        m1 = r1[2:0];
        m2 = r2[2:0];
        sb.push_back({s, r1[3], r2[3], 1'b0, sop_exp, 1'b0});
        sop_exp  = 1'b0;
        in_valid = 1'b1;
        in_sys   = s;
        in_itl   = t;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic push_tail();
        logic [4:0] r;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                r  = rsc_ref(m1, 1'b0, 1'b1);
                m1 = r[2:0];
            end else begin
                r  = rsc_ref(m2, 1'b0, 1'b1);
                m2 = r[2:0];
            end
            sb.push_back({r[4], r[3], 1'b0, 1'b1, 1'b0, (i == 5)});
        end
    endtask

    // kind: 0 zeros, 1 single impulse on sys, 2 random; inj adds a stray start and a stray in_valid
    task automatic run_data(input int k, input int kind, input bit gaps, input bit inj);
        logic s, t;
        for (int i = 0; i < k; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            case (kind)
                0:       begin s = 1'b0;         t = 1'b0;         end
                1:       begin s = (i == 0);     t = 1'b0;         end
                default: begin s = 1'($urandom); t = 1'($urandom); end
            endcase
            if (inj && i == 10) begin
                start   = 1'b1;
                blk_len = CNT_W'(40);
            end
            feed(s, t);
        end
        push_tail();
        if (inj) begin
            in_valid = 1'b1;
            in_sys   = 1'b1;
            in_itl   = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int exp_err);
        int cyc;
        cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_drain"}, sb.size(), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_err"}, int'(err), exp_err);
    endtask

    function automatic int all_outs();
        return int'({out_valid, out_sys, out_p1, out_p2, out_tail, out_sop, out_eop, busy, err});
    endfunction

    initial begin
        logic [6:0] c_imp;
        int         ones;
        c_imp = 7'b1111001;

        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: all-zero block
        start_block(40);
        check("t1_busy", int'(busy), 1);
        run_data(40, 0, 1'b0, 1'b0);
        wait_done("t1", 0);
        check("t1_count", n_out, 46);

        // 2: impulse response of RSC1
        start_block(40);
        run_data(40, 1, 1'b0, 1'b0);
        wait_done("t2", 0);
        for (int i = 0; i < 7; i++) check($sformatf("t2_p1_%0d", i), int'(cap_p1[i]), int'(c_imp[6-i]));
        ones = 0;
        foreach (cap_p2[i]) ones += int'(cap_p2[i]);
        check("t2_p2_zero", ones, 0);

        // 3: random data with stalls
        start_block(40);
        run_data(40, 2, 1'b1, 1'b0);
        wait_done("t3", 0);

        // 4: out-of-range lengths, then the largest legal length
        start = 1'b1; blk_len = CNT_W'(39); @(negedge clk); start = 1'b0;
        check("t4_err39", int'(err), 1);
        check("t4_busy39", int'(busy), 0);
        start = 1'b1; blk_len = CNT_W'(6145); @(negedge clk); start = 1'b0;
        check("t4_err6145", int'(err), 1);
        check("t4_busy6145", int'(busy), 0);
        repeat (4) @(negedge clk);
        start_block(6144);
        check("t4_err_clr", int'(err), 0);
        check("t4_busy", int'(busy), 1);
        run_data(6144, 2, 1'b0, 1'b0);
        wait_done("t4", 0);
        check("t4_count", n_out, 6150);

        // 5: stray start in DATA and stray in_valid in TAIL1
        start_block(40);
        run_data(40, 2, 1'b0, 1'b1);
        wait_done("t5", 1);

        // 6: reset partway through a block
        start_block(40);
        for (int i = 0; i < 20; i++) feed(1'($urandom), 1'($urandom));
        #2 n_rst = 1'b0;
        #1 check("t6_outs_reset", all_outs(), 0);
        sb.delete();
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("t6_idle", all_outs(), 0);
        start_block(40);
        run_data(40, 2, 1'b1, 1'b0);
        wait_done("t6", 0);
        check("t6_count", n_out, 46);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
